// File: rtl/gate_sweep_controller.sv
// Exhaustive stimulus sweep and self-check for the dual AND-OR gate block:
// drives all 1024 input vectors, waits a settle time, compares against a golden model.
module gate_sweep_controller #(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int unsigned ERR_W         = 11
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic             abort,
  output logic             p1_a,
  output logic             p1_b,
  output logic             p1_c,
  output logic             p1_d,
  output logic             p1_e,
  output logic             p1_f,
  output logic             p2_a,
  output logic             p2_b,
  output logic             p2_c,
  output logic             p2_d,
  input  logic             p1_y,
  input  logic             p2_y,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_cnt,
  output logic             fail_seen,
  output logic [9:0]       first_fail_vec
);

  localparam int unsigned CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  typedef enum logic [2:0] {
    IDLE,
    DRIVE,
    SETTLE,
    CHECK,
    DONE
  } state_e;

  state_e           state_q;
  logic [9:0]       vec_q;
  logic [CNT_W-1:0] cnt_q;
  logic [ERR_W-1:0] err_q;
  logic [ERR_W-1:0] err_d;
  logic             fail_q;
  logic [9:0]       ffv_q;
  logic             busy_q;
  logic             done_q;
  logic             pass_q;
  logic             exp1;
  logic             exp2;
  logic             mismatch;

  // Golden model evaluated on the vector currently being driven
  always_comb begin
    exp1     = (vec_q[0] & vec_q[1] & vec_q[2]) | (vec_q[3] & vec_q[4] & vec_q[5]);
    exp2     = (vec_q[6] & vec_q[7]) | (vec_q[8] & vec_q[9]);
    mismatch = (p1_y != exp1) || (p2_y != exp2);
    err_d    = err_q;
    if (mismatch && (err_q != '1)) begin
      err_d = err_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      vec_q   <= '0;
      cnt_q   <= '0;
      err_q   <= '0;
      fail_q  <= 1'b0;
      ffv_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else if (abort) begin
      // Results and stimulus are kept so an aborted run can still be inspected
      state_q <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            state_q <= DRIVE;
            vec_q   <= '0;
            err_q   <= '0;
            fail_q  <= 1'b0;
            ffv_q   <= '0;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
          end
        end
        DRIVE: begin
          cnt_q   <= '0;
          state_q <= SETTLE;
        end
        SETTLE: begin
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CNT_W'(SETTLE_CYCLES - 1)) begin
            state_q <= CHECK;
          end
        end
        CHECK: begin
          err_q <= err_d;
          if (mismatch && !fail_q) begin
            fail_q <= 1'b1;
            ffv_q  <= vec_q;
          end
          if (vec_q == 10'h3FF) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            pass_q  <= (err_d == '0);
          end else begin
            vec_q   <= vec_q + 10'd1;
            state_q <= DRIVE;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          pass_q  <= 1'b0;
        end
      endcase
    end
  end

  assign {p2_d, p2_c, p2_b, p2_a, p1_f, p1_e, p1_d, p1_c, p1_b, p1_a} = vec_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign pass           = pass_q;
  assign err_cnt        = err_q;
  assign fail_seen      = fail_q;
  assign first_fail_vec = ffv_q;

endmodule

// File: tb/tb_gate_sweep_controller.sv
// Directed bench for gate_sweep_controller with behavioural gate models (good, stuck, delayed).
module tb_gate_sweep_controller;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic resetn, abort, start0, start1, start2;
  int   mode0, mode1, mode2;
  int   checks = 0;
  int   errors = 0;

  wire  [9:0]  v0, v1, v2;
  logic        p1y0, p2y0, p1y1, p2y1, p1y2, p2y2;
  logic        busy0, done0, pass0, fs0;
  logic        busy1, done1, pass1, fs1;
  logic        busy2, done2, pass2, fs2;
  logic [10:0] err0, err2;
  logic [3:0]  err1;
  logic [9:0]  ffv0, ffv1, ffv2;
  logic [3:0][9:0] dl0, dl1, dl2;

  function automatic logic [1:0] gold(input logic [9:0] v);
    logic [1:0] g;
    g[0] = (v[0] & v[1] & v[2]) | (v[3] & v[4] & v[5]);
    g[1] = (v[6] & v[7]) | (v[8] & v[9]);
    return g;
  endfunction

  // mode: 0 good, 1 p2_y stuck-0, 2 p1_y stuck-0, 3 good but 4 cycles late
  function automatic logic [1:0] gate(input int mode, input logic [9:0] v, input logic [9:0] vd);
    logic [1:0] g;
    g = gold(v);
    case (mode)
      1: g[1] = 1'b0;
      2: g[0] = 1'b0;
      3: g = gold(vd);
      default: ;
    endcase
    return g;
  endfunction

  always @(posedge clk) begin
    dl0 <= {dl0[2:0], v0};
    dl1 <= {dl1[2:0], v1};
    dl2 <= {dl2[2:0], v2};
  end
  assign {p2y0, p1y0} = gate(mode0, v0, dl0[3]);
  assign {p2y1, p1y1} = gate(mode1, v1, dl1[3]);
  assign {p2y2, p1y2} = gate(mode2, v2, dl2[3]);

  gate_sweep_controller #(.SETTLE_CYCLES(2), .ERR_W(11)) dut0 (
    .clk(clk), .resetn(resetn), .start(start0), .abort(abort),
    .p1_a(v0[0]), .p1_b(v0[1]), .p1_c(v0[2]), .p1_d(v0[3]), .p1_e(v0[4]), .p1_f(v0[5]),
    .p2_a(v0[6]), .p2_b(v0[7]), .p2_c(v0[8]), .p2_d(v0[9]),
    .p1_y(p1y0), .p2_y(p2y0), .busy(busy0), .done(done0), .pass(pass0),
    .err_cnt(err0), .fail_seen(fs0), .first_fail_vec(ffv0)
  );

  gate_sweep_controller #(.SETTLE_CYCLES(2), .ERR_W(4)) dut1 (
    .clk(clk), .resetn(resetn), .start(start1), .abort(abort),
    .p1_a(v1[0]), .p1_b(v1[1]), .p1_c(v1[2]), .p1_d(v1[3]), .p1_e(v1[4]), .p1_f(v1[5]),
    .p2_a(v1[6]), .p2_b(v1[7]), .p2_c(v1[8]), .p2_d(v1[9]),
    .p1_y(p1y1), .p2_y(p2y1), .busy(busy1), .done(done1), .pass(pass1),
    .err_cnt(err1), .fail_seen(fs1), .first_fail_vec(ffv1)
  );

  gate_sweep_controller #(.SETTLE_CYCLES(5), .ERR_W(11)) dut2 (
    .clk(clk), .resetn(resetn), .start(start2), .abort(abort),
    .p1_a(v2[0]), .p1_b(v2[1]), .p1_c(v2[2]), .p1_d(v2[3]), .p1_e(v2[4]), .p1_f(v2[5]),
    .p2_a(v2[6]), .p2_b(v2[7]), .p2_c(v2[8]), .p2_d(v2[9]),
    .p1_y(p1y2), .p2_y(p2y2), .busy(busy2), .done(done2), .pass(pass2),
    .err_cnt(err2), .fail_seen(fs2), .first_fail_vec(ffv2)
  );

  // Returns #1 after the edge that samples start
  task automatic pulse_start(input int which);
    @(negedge clk);
    case (which)
      0: start0 = 1'b1;
      1: start1 = 1'b1;
      default: start2 = 1'b1;
    endcase
    @(posedge clk);
    #1;
    start0 = 1'b0;
    start1 = 1'b0;
    start2 = 1'b0;
  endtask

  task automatic wait_done(input int which, input int limit, output int edges, output bit ok);
    logic d;
    edges = 0;
    ok    = 1'b0;
    while (edges < limit && !ok) begin
      @(posedge clk);
      #1;
      edges++;
      case (which)
        0: d = done0;
        1: d = done1;
        default: d = done2;
      endcase
      if (d === 1'b1) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0; abort = 1'b0;
    start0 = 1'b0; start1 = 1'b0; start2 = 1'b0;
    mode0 = 0; mode1 = 0; mode2 = 0;
    #12;
    checks++;
    if ({v0, busy0, done0, pass0, fs0, err0, ffv0} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: vec=%0d busy=%b done=%b pass=%b fail_seen=%b err=%0d ffv=%0d, required all 0",
               v0, busy0, done0, pass0, fs0, err0, ffv0);
    end
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (busy0 !== 1'b0 || v0 !== 10'd0) begin
      errors++;
      $display("FAIL reset_idle: busy=%b vec=%0d, required busy=0 vec=0", busy0, v0);
    end
  endtask

  task automatic test_full_pass();
    int walk_bad;
    int n;
    int first_bad;
    walk_bad = 0; n = 0; first_bad = -1;
    mode0 = 0;
    pulse_start(0);
    while (n < 5000 && done0 !== 1'b1) begin
      if (v0 !== 10'(n / 4) || busy0 !== 1'b1) begin
        walk_bad++;
        if (first_bad < 0) first_bad = n;
      end
      @(posedge clk);
      #1;
      n++;
    end
    checks++;
    if (walk_bad != 0) begin
      errors++;
      $display("FAIL pass_walk: %0d bad cycles (first at edge %0d), required 0", walk_bad, first_bad);
    end
    checks++;
    if (n != 4096) begin
      errors++;
      $display("FAIL pass_latency: done after %0d edges, required 4096", n);
    end
    checks++;
    if ({done0, pass0, busy0, fs0} !== 4'b1100 || err0 !== 11'd0 || v0 !== 10'd1023) begin
      errors++;
      $display("FAIL pass_result: done=%b pass=%b busy=%b fail_seen=%b err=%0d vec=%0d, required 1 1 0 0 0 1023",
               done0, pass0, busy0, fs0, err0, v0);
    end
  endtask

  task automatic test_p2_stuck();
    int e; bit ok;
    mode0 = 1;
    pulse_start(0);
    wait_done(0, 5000, e, ok);
    checks++;
    if (!ok || err0 !== 11'd448 || ffv0 !== 10'd192 || fs0 !== 1'b1 || pass0 !== 1'b0) begin
      errors++;
      $display("FAIL p2_stuck: done=%b err=%0d ffv=%0d fail_seen=%b pass=%b, required 1 448 192 1 0",
               ok, err0, ffv0, fs0, pass0);
    end
  endtask

  task automatic test_p1_stuck();
    int e; bit ok;
    mode0 = 2;
    pulse_start(0);
    wait_done(0, 5000, e, ok);
    checks++;
    if (!ok || err0 !== 11'd240 || ffv0 !== 10'd7 || fs0 !== 1'b1 || pass0 !== 1'b0) begin
      errors++;
      $display("FAIL p1_stuck: done=%b err=%0d ffv=%0d fail_seen=%b pass=%b, required 1 240 7 1 0",
               ok, err0, ffv0, fs0, pass0);
    end
  endtask

  task automatic test_abort_start_priority();
    @(negedge clk);
    abort = 1'b1; start0 = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0; start0 = 1'b0;
    checks++;
    if (busy0 !== 1'b0 || done0 !== 1'b0 || pass0 !== 1'b0 || v0 !== 10'd1023 || err0 !== 11'd240) begin
      errors++;
      $display("FAIL abort_beats_start: busy=%b done=%b pass=%b vec=%0d err=%0d, required 0 0 0 1023 240",
               busy0, done0, pass0, v0, err0);
    end
  endtask

  task automatic test_err_saturate();
    int e; bit ok;
    mode1 = 1;
    pulse_start(1);
    wait_done(1, 5000, e, ok);
    checks++;
    if (!ok || err1 !== 4'd15 || ffv1 !== 10'd192 || pass1 !== 1'b0) begin
      errors++;
      $display("FAIL err_saturate: done=%b err=%0d ffv=%0d pass=%b, required 1 15 192 0", ok, err1, ffv1, pass1);
    end
  endtask

  task automatic test_delayed_settle5();
    int e; bit ok;
    mode2 = 3;
    pulse_start(2);
    wait_done(2, 9000, e, ok);
    checks++;
    if (!ok || e != 7168) begin
      errors++;
      $display("FAIL settle5_latency: done=%b after %0d edges, required 7168", ok, e);
    end
    checks++;
    if (pass2 !== 1'b1 || err2 !== 11'd0 || fs2 !== 1'b0) begin
      errors++;
      $display("FAIL settle5_result: pass=%b err=%0d fail_seen=%b, required 1 0 0", pass2, err2, fs2);
    end
  endtask

  task automatic test_delayed_settle2();
    int e; bit ok;
    mode0 = 3;
    pulse_start(0);
    wait_done(0, 5000, e, ok);
    checks++;
    if (!ok || pass0 !== 1'b0 || err0 === 11'd0 || fs0 !== 1'b1) begin
      errors++;
      $display("FAIL settle2_delayed: done=%b pass=%b err=%0d fail_seen=%b, required 1 0 nonzero 1",
               ok, pass0, err0, fs0);
    end
  endtask

  task automatic test_abort();
    int n;
    n = 0;
    mode0 = 2;
    pulse_start(0);
    while (n < 1000 && v0 !== 10'd100) begin
      @(posedge clk);
      #1;
      n++;
    end
    checks++;
    if (v0 !== 10'd100) begin
      errors++;
      $display("FAIL abort_reach_vec: vec=%0d, required 100", v0);
    end
    @(negedge clk);
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    // vectors 0..99 with exp1=1: 15 below 64 plus 71,79,87,95
    checks++;
    if (busy0 !== 1'b0 || done0 !== 1'b0 || err0 !== 11'd19 || fs0 !== 1'b1 || ffv0 !== 10'd7 || v0 !== 10'd100) begin
      errors++;
      $display("FAIL abort_hold: busy=%b done=%b err=%0d fail_seen=%b ffv=%0d vec=%0d, required 0 0 19 1 7 100",
               busy0, done0, err0, fs0, ffv0, v0);
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (busy0 !== 1'b0 || v0 !== 10'd100) begin
      errors++;
      $display("FAIL abort_stays_idle: busy=%b vec=%0d, required 0 100", busy0, v0);
    end
    pulse_start(0);
    checks++;
    if (busy0 !== 1'b1 || v0 !== 10'd0 || err0 !== 11'd0 || fs0 !== 1'b0 || ffv0 !== 10'd0) begin
      errors++;
      $display("FAIL abort_restart: busy=%b vec=%0d err=%0d fail_seen=%b ffv=%0d, required 1 0 0 0 0",
               busy0, v0, err0, fs0, ffv0);
    end
    @(negedge clk);
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
  endtask

  task automatic test_start_while_busy();
    int n;
    n = 0;
    mode0 = 2;
    pulse_start(0);
    while (n < 6000 && done0 !== 1'b1) begin
      @(negedge clk);
      start0 = (n == 10 || n == 2000);
      @(posedge clk);
      #1;
      start0 = 1'b0;
      n++;
    end
    checks++;
    if (n != 4096 || err0 !== 11'd240 || ffv0 !== 10'd7) begin
      errors++;
      $display("FAIL start_while_busy: done after %0d edges err=%0d ffv=%0d, required 4096 240 7", n, err0, ffv0);
    end
  endtask

  task automatic test_restart_and_async_reset();
    int n;
    n = 0;
    mode0 = 2;
    pulse_start(0);
    checks++;
    if (busy0 !== 1'b1 || done0 !== 1'b0 || pass0 !== 1'b0 || v0 !== 10'd0 || err0 !== 11'd0) begin
      errors++;
      $display("FAIL restart_from_done: busy=%b done=%b pass=%b vec=%0d err=%0d, required 1 0 0 0 0",
               busy0, done0, pass0, v0, err0);
    end
    while (n < 200 && v0 !== 10'd8) begin
      @(posedge clk);
      #1;
      n++;
    end
    @(posedge clk);
    #2;
    resetn = 1'b0;
    #1;
    checks++;
    if ({v0, busy0, done0, pass0, fs0, err0, ffv0} !== '0) begin
      errors++;
      $display("FAIL async_reset: vec=%0d busy=%b done=%b pass=%b fail_seen=%b err=%0d ffv=%0d, required all 0",
               v0, busy0, done0, pass0, fs0, err0, ffv0);
    end
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (busy0 !== 1'b0 || v0 !== 10'd0 || err0 !== 11'd0) begin
      errors++;
      $display("FAIL reset_back_idle: busy=%b vec=%0d err=%0d, required 0 0 0", busy0, v0, err0);
    end
  endtask

  initial begin
    test_reset();
    test_full_pass();
    test_p2_stuck();
    test_p1_stuck();
    test_abort_start_priority();
    test_err_saturate();
    test_delayed_settle5();
    test_delayed_settle2();
    test_abort();
    test_start_while_busy();
    test_restart_and_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
